// File: rtl/occupancy_arbiter.sv
// Round-robin arbiter sharing one up/down occupancy counter between several requesters.
// Keeps a shadow count so a grant can never push the counter past full or below empty.
module occupancy_arbiter #(
    parameter int N_REQ      = 4,
    parameter int CNT_W      = 3,
    parameter int MAX_CNT    = 7,
    parameter int SETTLE_CYC = 2
) (
    input  logic             i_clk,
    input  logic             i_mr_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_dir,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_up,
    output logic             o_down,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ef,
    output logic             o_ff,
    output logic             o_busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(MAX_CNT);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYC - 1);
    localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_winner;
    logic             r_winDir;
    logic [CNT_W-1:0] r_cnt;
    logic [SET_W-1:0] r_settle;

    logic [N_REQ-1:0] w_elig;
    logic             w_notFull;
    logic             w_notEmpty;
    logic             w_any;
    logic [PTR_W-1:0] w_winner;

    assign w_notFull  = (r_cnt != FULL_CNT);
    assign w_notEmpty = (r_cnt != '0);

    // A request only counts if the shadow count can absorb its step; others just stay pending.
    assign w_elig = i_req & ((i_dir & {N_REQ{w_notFull}}) | (~i_dir & {N_REQ{w_notEmpty}}));
    assign w_any  = |w_elig;

    // Scanning from the far end down lets the nearest eligible index at or after the pointer win.
    always_comb begin
        w_winner = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_elig[(int'(r_ptr) + k) % N_REQ]) begin
                w_winner = PTR_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_mr_n) begin
        if (!i_mr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_nextState = GRANT;
                end
            end
            GRANT: begin
                w_nextState = SETTLE;
            end
            SETTLE: begin
                if (r_settle == LAST_SETTLE) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The shadow count moves on the decision edge so the new value is visible during the grant cycle.
    always_ff @(posedge i_clk or negedge i_mr_n) begin
        if (!i_mr_n) begin
            r_ptr    <= '0;
            r_winner <= '0;
            r_winDir <= 1'b0;
            r_cnt    <= '0;
            r_settle <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_winner <= w_winner;
                        r_winDir <= i_dir[w_winner];
                        r_ptr    <= (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
                        r_cnt    <= i_dir[w_winner] ? r_cnt + 1'b1 : r_cnt - 1'b1;
                    end
                end
                GRANT: begin
                    r_settle <= '0;
                end
                SETTLE: begin
                    r_settle <= r_settle + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_gnt  = '0;
        o_up   = 1'b0;
        o_down = 1'b0;
        o_busy = 1'b0;
        case (r_state)
            GRANT: begin
                o_gnt  = N_REQ'(1) << r_winner;
                o_up   = r_winDir;
                o_down = ~r_winDir;
                o_busy = 1'b1;
            end
            SETTLE: begin
                o_busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign o_cnt = r_cnt;
    assign o_ef  = (r_cnt == '0);
    assign o_ff  = (r_cnt == FULL_CNT);

endmodule
